// File: rtl/des_pkg.sv
// DES constants shared by the round engine: FIPS 46-3 permutation and S-box tables, FSM states.
// Table entries use DES bit numbering (bit 1 = MSB), matching the 64-bit bus convention of the engine.
package des_pkg;

  localparam int NUM_ROUNDS = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int IP_TBL [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2,
    60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6,
    64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1,
    59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5,
    63, 55, 47, 39, 31, 23, 15, 7
  };

  localparam int FP_TBL [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32,
    39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30,
    37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28,
    35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26,
    33, 1, 41,  9, 49, 17, 57, 25
  };

  localparam int E_TBL [48] = '{
    32,  1,  2,  3,  4,  5,
     4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13,
    12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21,
    20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29,
    28, 29, 30, 31, 32,  1
  };

  localparam int P_TBL [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,
     1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9,
    19, 13, 30,  6, 22, 11,  4, 25
  };

  // Each box is stored row-major: entry = row*16 + column.
  localparam int SBOX [8][64] = '{
    '{14,  4, 13,  1,  2, 15, 11,  8,  3, 10,  6, 12,  5,  9,  0,  7,
       0, 15,  7,  4, 14,  2, 13,  1, 10,  6, 12, 11,  9,  5,  3,  8,
       4,  1, 14,  8, 13,  6,  2, 11, 15, 12,  9,  7,  3, 10,  5,  0,
      15, 12,  8,  2,  4,  9,  1,  7,  5, 11,  3, 14, 10,  0,  6, 13},
    '{15,  1,  8, 14,  6, 11,  3,  4,  9,  7,  2, 13, 12,  0,  5, 10,
       3, 13,  4,  7, 15,  2,  8, 14, 12,  0,  1, 10,  6,  9, 11,  5,
       0, 14,  7, 11, 10,  4, 13,  1,  5,  8, 12,  6,  9,  3,  2, 15,
      13,  8, 10,  1,  3, 15,  4,  2, 11,  6,  7, 12,  0,  5, 14,  9},
    '{10,  0,  9, 14,  6,  3, 15,  5,  1, 13, 12,  7, 11,  4,  2,  8,
      13,  7,  0,  9,  3,  4,  6, 10,  2,  8,  5, 14, 12, 11, 15,  1,
      13,  6,  4,  9,  8, 15,  3,  0, 11,  1,  2, 12,  5, 10, 14,  7,
       1, 10, 13,  0,  6,  9,  8,  7,  4, 15, 14,  3, 11,  5,  2, 12},
    '{ 7, 13, 14,  3,  0,  6,  9, 10,  1,  2,  8,  5, 11, 12,  4, 15,
      13,  8, 11,  5,  6, 15,  0,  3,  4,  7,  2, 12,  1, 10, 14,  9,
      10,  6,  9,  0, 12, 11,  7, 13, 15,  1,  3, 14,  5,  2,  8,  4,
       3, 15,  0,  6, 10,  1, 13,  8,  9,  4,  5, 11, 12,  7,  2, 14},
    '{ 2, 12,  4,  1,  7, 10, 11,  6,  8,  5,  3, 15, 13,  0, 14,  9,
      14, 11,  2, 12,  4,  7, 13,  1,  5,  0, 15, 10,  3,  9,  8,  6,
       4,  2,  1, 11, 10, 13,  7,  8, 15,  9, 12,  5,  6,  3,  0, 14,
      11,  8, 12,  7,  1, 14,  2, 13,  6, 15,  0,  9, 10,  4,  5,  3},
    '{12,  1, 10, 15,  9,  2,  6,  8,  0, 13,  3,  4, 14,  7,  5, 11,
      10, 15,  4,  2,  7, 12,  9,  5,  6,  1, 13, 14,  0, 11,  3,  8,
       9, 14, 15,  5,  2,  8, 12,  3,  7,  0,  4, 10,  1, 13, 11,  6,
       4,  3,  2, 12,  9,  5, 15, 10, 11, 14,  1,  7,  6,  0,  8, 13},
    '{ 4, 11,  2, 14, 15,  0,  8, 13,  3, 12,  9,  7,  5, 10,  6,  1,
      13,  0, 11,  7,  4,  9,  1, 10, 14,  3,  5, 12,  2, 15,  8,  6,
       1,  4, 11, 13, 12,  3,  7, 14, 10, 15,  6,  8,  0,  5,  9,  2,
       6, 11, 13,  8,  1,  4, 10,  7,  9,  5,  0, 15, 14,  2,  3, 12},
    '{13,  2,  8,  4,  6, 15, 11,  1, 10,  9,  3, 14,  5,  0, 12,  7,
       1, 15, 13,  8, 10,  3,  7,  4, 12,  5,  6, 11,  0, 14,  9,  2,
       7, 11,  4,  1,  9, 12, 14,  2,  0,  6, 10, 13, 15,  3,  5,  8,
       2,  1, 14,  7,  4, 10,  8, 13, 15, 12,  9,  0,  3,  5,  6, 11}
  };

  function automatic logic [63:0] ip_perm(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 64; i++) y[63-i] = x[64-IP_TBL[i]];
    return y;
  endfunction

  function automatic logic [63:0] fp_perm(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 64; i++) y[63-i] = x[64-FP_TBL[i]];
    return y;
  endfunction

  function automatic logic [47:0] e_expand(input logic [31:0] x);
    logic [47:0] y;
    for (int i = 0; i < 48; i++) y[47-i] = x[32-E_TBL[i]];
    return y;
  endfunction

  function automatic logic [31:0] p_perm(input logic [31:0] x);
    logic [31:0] y;
    for (int i = 0; i < 32; i++) y[31-i] = x[32-P_TBL[i]];
    return y;
  endfunction

  // Outer bits select the row, inner four bits the column.
  function automatic logic [3:0] sbox_lookup(input int box, input logic [5:0] b);
    logic [5:0] idx;
    idx = {b[5], b[0], b[4:1]};
    return 4'(SBOX[box][idx]);
  endfunction

endpackage

// File: rtl/des_f.sv
// DES round function f(R, K): expand, key mix, S-box substitution, P permutation.
// Purely combinational; no handshake.
module des_f
  import des_pkg::*;
(
  input  logic [31:0] r,
  input  logic [47:0] k,
  output logic [31:0] f
);

  logic [47:0] mixed;
  logic [31:0] subst;

  always_comb begin
    mixed = e_expand(r) ^ k;
    subst = '0;
    for (int j = 0; j < 8; j++) begin
      subst[31-4*j -: 4] = sbox_lookup(j, mixed[47-6*j -: 6]);
    end
    f = p_perm(subst);
  end

endmodule

// File: rtl/des_round_engine.sv
// Iterative DES block engine, one Feistel round per cycle; out_valid rises 16 cycles after acceptance.
// Result is held on dout until out_ready; no new block is accepted until the result has been taken.
module des_round_engine
  import des_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         decrypt,
  input  logic [63:0]  din,
  input  logic [767:0] rkeys,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [63:0]  dout
);

  state_t       state;
  state_t       state_nxt;
  logic [3:0]   ctr;
  logic [31:0]  l_q;
  logic [31:0]  r_q;
  logic [767:0] keys_q;
  logic         dec_q;
  logic [63:0]  dout_q;
  logic [47:0]  round_key;
  logic [31:0]  f_out;
  logic         accept;
  logic         last_round;
  int           kidx;

  assign in_ready   = (state == IDLE);
  assign out_valid  = (state == DONE);
  assign dout       = dout_q;
  assign accept     = in_valid && in_ready;
  assign last_round = (ctr == 4'(NUM_ROUNDS - 1));

  // Decryption walks the same schedule backwards: key 16 first.
  always_comb begin
    kidx      = dec_q ? (NUM_ROUNDS - 1 - int'(ctr)) : int'(ctr);
    round_key = keys_q[767 - 48*kidx -: 48];
  end

  des_f u_f (
    .r (r_q),
    .k (round_key),
    .f (f_out)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)   state_nxt = ROUND;
      ROUND:   if (last_round) state_nxt = DONE;
      DONE:    if (out_ready)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctr    <= '0;
      l_q    <= '0;
      r_q    <= '0;
      dout_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            {l_q, r_q} <= ip_perm(din);
            ctr        <= '0;
          end
        end
        ROUND: begin
          l_q <= r_q;
          r_q <= l_q ^ f_out;
          ctr <= ctr + 4'd1;
          // Final swap: output is R16 || L16 before FP.
          if (last_round) dout_q <= fp_perm({l_q ^ f_out, r_q});
        end
        default: ;
      endcase
    end
  end

  // Operands are captured only at acceptance so upstream may change them while busy.
  always_ff @(posedge clk) begin
    if (accept) begin
      keys_q <= rkeys;
      dec_q  <= decrypt;
    end
  end

endmodule

// File: tb/tb_des_round_engine.sv
// Scoreboard bench for des_round_engine: random and known-answer blocks against a loop-based DES model.
module tb_des_round_engine;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic         decrypt;
  logic [63:0]  din;
  logic [767:0] rkeys;
  logic         out_valid;
  logic         out_ready;
  logic [63:0]  dout;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  des_round_engine dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .decrypt(decrypt), .din(din), .rkeys(rkeys), .out_valid(out_valid),
    .out_ready(out_ready), .dout(dout)
  );

  // ---------------- reference model (FIPS 46-3, bit 1 = MSB) ----------------
  int IP_T[$]  = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4, 62,54,46,38,30,22,14,6,
                   64,56,48,40,32,24,16,8, 57,49,41,33,25,17,9,1, 59,51,43,35,27,19,11,3,
                   61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
  int E_T[$]   = '{32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
                   16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
  int P_T[$]   = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
                   2,8,24,14,32,27,3,9, 19,13,30,6,22,11,4,25};
  int PC1_T[$] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18, 10,2,59,51,43,35,27,
                   19,11,3,60,52,44,36, 63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                   14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
  int PC2_T[$] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
                   41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
  int SH_T[$]  = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
  int S_T [8][4][16] = '{
    '{'{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7}, '{0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8},
      '{4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0}, '{15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13}},
    '{'{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10}, '{3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5},
      '{0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15}, '{13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9}},
    '{'{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8}, '{13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1},
      '{13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7}, '{1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12}},
    '{'{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15}, '{13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9},
      '{10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4}, '{3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14}},
    '{'{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9}, '{14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6},
      '{4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14}, '{11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3}},
    '{'{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11}, '{10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8},
      '{9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6}, '{4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13}},
    '{'{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1}, '{13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6},
      '{1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2}, '{6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12}},
    '{'{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7}, '{1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2},
      '{7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8}, '{2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}}
  };

  // Output bit i (1-based) takes input bit tbl[i] of a w-bit word; result right-aligned.
  function automatic logic [63:0] perm(input logic [63:0] x, input int w, input int tbl[$]);
    logic [63:0] y = '0;
    for (int i = 0; i < tbl.size(); i++) y[tbl.size()-1-i] = x[w - tbl[i]];
    return y;
  endfunction

  // FP is the inverse of IP: put bit i back where IP took it from.
  function automatic logic [63:0] inv_ip(input logic [63:0] y);
    logic [63:0] z = '0;
    for (int i = 0; i < 64; i++) z[64 - IP_T[i]] = y[63-i];
    return z;
  endfunction

  function automatic logic [31:0] f_ref(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] e;
    logic [31:0] s = '0;
    logic [5:0]  six;
    e = perm({32'h0, r}, 32, E_T)[47:0] ^ k;
    for (int j = 0; j < 8; j++) begin
      six = e[47-6*j -: 6];
      s = (s << 4) | 32'(S_T[j][six[5]*2 + six[0]][six[4:1]]);
    end
    return perm({32'h0, s}, 32, P_T)[31:0];
  endfunction

  function automatic logic [767:0] key_sched(input logic [63:0] key);
    logic [55:0]  cd;
    logic [27:0]  c, d;
    logic [767:0] rk = '0;
    cd = perm(key, 64, PC1_T)[55:0];
    c = cd[55:28];
    d = cd[27:0];
    for (int i = 0; i < 16; i++) begin
      for (int s = 0; s < SH_T[i]; s++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      rk[767-48*i -: 48] = perm({8'h0, c, d}, 56, PC2_T)[47:0];
    end
    return rk;
  endfunction

  function automatic logic [63:0] des_ref(input logic [63:0] blk, input logic [767:0] rk, input bit dec);
    logic [63:0] y;
    logic [31:0] l, r, t;
    int n;
    y = perm(blk, 64, IP_T);
    l = y[63:32];
    r = y[31:0];
    for (int i = 0; i < 16; i++) begin
      n = dec ? 15 - i : i;
      t = l ^ f_ref(r, rk[767-48*n -: 48]);
      l = r;
      r = t;
    end
    return inv_ip({r, l});
  endfunction

  function automatic logic [767:0] rand768();
    logic [767:0] v;
    for (int i = 0; i < 24; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // ---------------- monitor ----------------
  logic        prev_vld = 1'b0;
  logic [63:0] prev_dout = '0;
  logic [63:0] exp_v;

  always @(negedge clk) begin
    if (rst_n === 1'b1 && in_valid === 1'b1 && in_ready === 1'b1) acc_cyc = cyc + 1;
    if (out_valid === 1'b1) begin
      if (!prev_vld) chk("latency", 64'(cyc - acc_cyc), 64'd16);
      else           chk("dout_stable", dout, prev_dout);
      if (out_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output actual=%h required=none", dout);
        end else begin
          exp_v = exp_q.pop_front();
          chk("dout", dout, exp_v);
        end
      end
    end
    prev_vld  = (out_valid === 1'b1);
    prev_dout = dout;
  end

  // ---------------- stimulus ----------------
  task automatic offer(input logic [63:0] blk, input logic [767:0] rk, input bit dec);
    int n = 0;
    din = blk; rkeys = rk; decrypt = dec; in_valid = 1'b1;
    while (in_ready !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
    if (in_ready !== 1'b1) chk("accept_timeout", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic run_block(input logic [63:0] blk, input logic [767:0] rk, input bit dec,
                           input int hold, input bit early);
    int n = 0;
    exp_q.push_back(des_ref(blk, rk, dec));
    out_ready = early;
    offer(blk, rk, dec);
    // Noise on the inputs while the block is in flight must not matter.
    while (out_valid !== 1'b1 && n < 40) begin
      in_valid = 1'($urandom_range(0, 1));
      din = {$urandom, $urandom};
      rkeys = rand768();
      decrypt = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    if (out_valid !== 1'b1) begin
      chk("done_timeout", 64'(out_valid), 64'd1);
      return;
    end
    if (!early) begin
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        chk("bp_out_valid", 64'(out_valid), 64'd1);
      end
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("ready_after_hs", 64'(in_ready), 64'd1);
    chk("valid_after_hs", 64'(out_valid), 64'd0);
  endtask

  logic [767:0] ks1, ks2;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; decrypt = 1'b0; din = '0; rkeys = '0;
    ks1 = key_sched(64'h133457799BBCDFF1);
    ks2 = key_sched(64'h0E329232EA6D0D73);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_dout", dout, 64'h0);
    rst_n = 1'b1;

    // Known-answer vectors: the model must agree with the published values first.
    chk("model_enc", des_ref(64'h0123456789ABCDEF, ks1, 1'b0), 64'h85E813540F0AB405);
    chk("model_dec", des_ref(64'h85E813540F0AB405, ks1, 1'b1), 64'h0123456789ABCDEF);
    chk("model_vec2", des_ref(64'h8787878787878787, ks2, 1'b0), 64'h0000000000000000);
    run_block(64'h0123456789ABCDEF, ks1, 1'b0, 0, 1'b0);
    run_block(64'h85E813540F0AB405, ks1, 1'b1, 0, 1'b1);
    run_block(64'h8787878787878787, ks2, 1'b0, 1, 1'b0);
    run_block(64'h0123456789ABCDEF, ks1, 1'b0, 10, 1'b0);

    for (int i = 0; i < 24; i++) begin
      run_block({$urandom, $urandom},
                (i % 2 == 0) ? key_sched({$urandom, $urandom}) : rand768(),
                1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    // Abort a block in round 7; nothing may come out for it.
    out_ready = 1'b1;
    offer(64'h0123456789ABCDEF, ks1, 1'b0);
    repeat (6) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("abort_out_valid", 64'(out_valid), 64'd0);
    chk("abort_dout", dout, 64'h0);
    chk("abort_in_ready", 64'(in_ready), 64'd1);
    repeat (25) @(posedge clk);
    #1;
    chk("abort_no_output", 64'(out_valid), 64'd0);
    out_ready = 1'b0;
    run_block(64'h0123456789ABCDEF, ks1, 1'b0, 2, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
